// File: rtl/muldiv_div_sequencer_if.sv
// Datapath <-> divide sequencer bus.
// Handshake: the datapath holds `start` high, with stable funct3/rs1_data/rs2_data,
// for as long as the divide instruction is current. The sequencer answers with
// `stall` until the cycle in which `result_valid` is high. The datapath commits
// `result` on the clock edge that ends that cycle. `flush` aborts at any time.
interface muldiv_div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    // Datapath side
    modport master (
        output start, funct3, rs1_data, rs2_data, flush,
        input  stall, busy, result_valid, result
    );

    // Sequencer side
    modport slave (
        input  start, funct3, rs1_data, rs2_data, flush,
        output stall, busy, result_valid, result
    );
endinterface

// File: rtl/muldiv_div_sequencer.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) using radix-2 restoring
// division, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// |dividend| < |divisor| finish directly from IDLE in a single cycle.
module muldiv_div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN+1)
) (
    input  logic                       clk,
    input  logic                       rst,
    muldiv_div_sequencer_if.slave      bus,
    output logic [1:0]                 o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_rem, r_quo, r_div, r_rs1, r_result;
    logic            r_qsign, r_rsign, r_op_rem, r_div0, r_ovf;

    // Accept-time operand decode
    logic            w_signed, w_accept, w_div0, w_ovf;
    logic [XLEN-1:0] w_abs1, w_abs2;
    logic            w_unused_f3;

    // Per-iteration datapath and final result
    logic [XLEN:0]   w_shift, w_trial;
    logic            w_take;
    logic [XLEN-1:0] w_step_rem, w_step_quo, w_q_fix, w_r_fix, w_final;

    // funct3[2] is the datapath's decode; only funct3[1:0] matter here.
    assign w_unused_f3 = bus.funct3[2];

    assign w_signed = ~bus.funct3[0];
    assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;
    assign w_abs1   = (w_signed & bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
    assign w_abs2   = (w_signed & bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
    assign w_div0   = (bus.rs2_data == '0);
    assign w_ovf    = w_signed & (bus.rs1_data == MIN_NEG) & (bus.rs2_data == '1);

    // Shift {rem,quo} left and trial-subtract; the XLEN+1-bit difference is
    // negative exactly when the shifted remainder is below the divisor.
    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_take     = ~w_trial[XLEN];
    assign w_step_rem = w_take ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_step_quo = {r_quo[XLEN-2:0], w_take};

    // Sign fix-up then special-case override, evaluated on the last CALC step
    assign w_q_fix = r_qsign ? -w_step_quo : w_step_quo;
    assign w_r_fix = r_rsign ? -w_step_rem : w_step_rem;
    always_comb begin
        w_final = r_op_rem ? w_r_fix : w_q_fix;
        if (r_div0) begin
            w_final = r_op_rem ? r_rs1 : '1;
        end else if (r_ovf) begin
            w_final = r_op_rem ? '0 : MIN_NEG;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    logic            w_early;
    logic [XLEN-1:0] w_early_res;
    assign w_early = w_div0 | w_ovf | (w_abs1 < w_abs2);
    // Short-circuit results: div0, overflow, or quotient 0 / remainder = rs1
    always_comb begin
        w_early_res = bus.funct3[1] ? bus.rs1_data : '0;
        if (w_div0) begin
            w_early_res = bus.funct3[1] ? bus.rs1_data : '1;
        end else if (w_ovf) begin
            w_early_res = bus.funct3[1] ? '0 : MIN_NEG;
        end
    end
`endif

    // Next-state logic; flush wins over every transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
`ifdef DIV_EARLY_OUT_EN
                    w_next_state = w_early ? S_DONE : S_CALC;
`else
                    w_next_state = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (bus.flush) begin
            w_next_state = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch at accept, one division step per CALC cycle, result load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_rs1    <= '0;
            r_result <= '0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_op_rem <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs1;
            r_div    <= w_abs2;
            r_rs1    <= bus.rs1_data;
            r_qsign  <= w_signed & (bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1]);
            r_rsign  <= w_signed & bus.rs1_data[XLEN-1];
            r_op_rem <= bus.funct3[1];
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
                r_result <= w_early_res;
            end
`endif
        end else if ((r_state == S_CALC) && !bus.flush) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
                r_result <= w_final;
            end
        end
    end

    assign bus.stall        = bus.start & (r_state != S_DONE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.result       = r_result;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_muldiv_div_sequencer.sv
// Bench for muldiv_div_sequencer: directed divide vectors with hand-computed
// results, queued by the driver and checked by an independent monitor.
module tb_muldiv_div_sequencer;
    localparam int XLEN = 32;
    localparam int FULL_LAT = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = XLEN + 1;
`endif
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_div_sequencer_if #(.XLEN(XLEN)) dut_if ();

    muldiv_div_sequencer #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .bus         (dut_if),
        .o_dbg_state (dbg_state)
    );

    // Scoreboard
    logic [XLEN-1:0] exp_q[$];
    int              exp_cyc_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every result_valid cycle pops one expected result and its cycle
    always @(negedge clk) begin
        logic [XLEN-1:0] e;
        int c;
        if (rst_n && dut_if.result_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got result 0x%08h with nothing expected (t=%0t)",
                         dut_if.result, $time);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("result", dut_if.result, e);
                check_int("valid_cycle", cyc, c);
            end
        end
    end

    // Driver: present one request, count stall cycles until result_valid
    task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int lat, input bit keep_start);
        int  stall_cnt = 0;
        bit  seen = 0;
        @(negedge clk);
        dut_if.start    = 1'b1;
        dut_if.funct3   = f3;
        dut_if.rs1_data = a;
        dut_if.rs2_data = b;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + lat);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (dut_if.stall) stall_cnt++;
            if (dut_if.result_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no result_valid expected one within 100 cycles (t=%0t)", $time);
        end
        check_int("stall_cycles", stall_cnt, lat);
        if (!keep_start) dut_if.start = 1'b0;
    endtask

    initial begin
        dut_if.start    = 1'b0;
        dut_if.funct3   = 3'b000;
        dut_if.rs1_data = '0;
        dut_if.rs2_data = '0;
        dut_if.flush    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_result", dut_if.result, 32'h0);
        check("rst_busy", {31'b0, dut_if.busy}, 32'h0);
        check("rst_valid", {31'b0, dut_if.result_valid}, 32'h0);
        check("rst_state", {30'b0, dbg_state}, 32'h0);
        rst_n = 1'b1;

        // Basic unsigned and signed vectors
        run_op(F_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT, 0);
        run_op(F_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT, 0);
        run_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT, 0);
        run_op(F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT, 0);
        run_op(F_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, FULL_LAT, 0);

        // Special cases
        run_op(F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 0);
        run_op(F_REM,  32'd5, 32'd0, 32'd5, SPEC_LAT, 0);
        run_op(F_REMU, 32'd77, 32'd0, 32'd77, SPEC_LAT, 0);
        run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, 0);
        run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPEC_LAT, 0);
        run_op(F_DIVU, 32'd3, 32'd10, 32'd0, SPEC_LAT, 0);
        run_op(F_REM,  32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, SPEC_LAT, 0);

        // Back-to-back with start held high throughout
        run_op(F_DIVU, 32'd1000, 32'd10, 32'd100, FULL_LAT, 1);
        run_op(F_DIV,  32'd50, 32'hFFFF_FFFB, 32'hFFFF_FFF6, FULL_LAT, 0);

        // Flush in CALC cycle 10
        @(negedge clk);
        dut_if.start = 1'b1;
        dut_if.funct3 = F_DIVU;
        dut_if.rs1_data = 32'd1234;
        dut_if.rs2_data = 32'd7;
        repeat (10) @(negedge clk);
        dut_if.flush = 1'b1;
        @(negedge clk);
        #1;
        check("flush_busy", {31'b0, dut_if.busy}, 32'h0);
        check("flush_result_held", dut_if.result, 32'hFFFF_FFF6);
        @(negedge clk);
        #1;
        check("flush_blocks_accept", {31'b0, dut_if.busy}, 32'h0);
        dut_if.flush = 1'b0;
        dut_if.start = 1'b0;
        run_op(F_DIVU, 32'd20, 32'd4, 32'd5, FULL_LAT, 0);

        // Asynchronous reset mid-CALC, between clock edges
        @(negedge clk);
        dut_if.start = 1'b1;
        dut_if.funct3 = F_DIVU;
        dut_if.rs1_data = 32'd50;
        dut_if.rs2_data = 32'd5;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        dut_if.start = 1'b0;
        #1;
        check("arst_result", dut_if.result, 32'h0);
        check("arst_busy", {31'b0, dut_if.busy}, 32'h0);
        check("arst_valid", {31'b0, dut_if.result_valid}, 32'h0);
        check("arst_stall", {31'b0, dut_if.stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(F_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT, 0);

        // Drain
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_int("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
